// File: rtl/move_input.sv
// Button conditioner: synchronizes, debounces and edge-detects three raw buttons,
// with optional auto-repeat, and drives arbitrated one-cycle move pulses.

// state  | meaning
// IDLE   | debounced level low, no pulses
// FIRST  | held, waiting REPEAT_DELAY for the first repeat pulse
// REPEAT | held, repeat pulse every REPEAT_PERIOD
module move_input_chan #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  logic          sync_1, sync_2;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic          db_done;
  logic          rise, fall;

  state_t        state_q, state_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;

  // The FSM reacts to the toggle decision itself so the press request is
  // captured by the output stage on the same edge that updates stable.
  assign db_done = (sync_2 != stable) && (db_cnt == DB_LAST);
  assign rise    = db_done & ~stable;
  assign fall    = db_done & stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        db_cnt <= '0;
      end else if (db_done) begin
        stable <= ~stable;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    req       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          req       = 1'b1;
          rpt_cnt_d = '0;
          state_d   = FIRST;
        end
      end
      FIRST: begin
        if (fall) begin
          rpt_cnt_d = '0;
          state_d   = IDLE;
        end else if (REPEAT_DELAY != 0) begin
          if (rpt_cnt_q == DELAY_LAST) begin
            req       = 1'b1;
            rpt_cnt_d = '0;
            state_d   = REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          rpt_cnt_d = '0;
          state_d   = IDLE;
        end else if (rpt_cnt_q == PERIOD_LAST) begin
          req       = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        rpt_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

module move_input #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_right,
  output logic moveup,
  output logic movedown,
  output logic moveright
);

  logic req_up, req_down, req_right;

  move_input_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .req  (req_up)
  );

  move_input_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .req  (req_down)
  );

  move_input_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_right),
    .req  (req_right)
  );

  // Opposing vertical requests cancel; the channel FSMs keep running regardless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moveup    <= 1'b0;
      movedown  <= 1'b0;
      moveright <= 1'b0;
    end else begin
      moveup    <= req_up & ~req_down;
      movedown  <= req_down & ~req_up;
      moveright <= req_right;
    end
  end

endmodule

// File: tb/tb_move_input.sv
// Scoreboard bench for move_input: two DUTs (auto-repeat on and off) share the
// button stimulus and are checked against an event-level reference model.
module tb_move_input;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_right = 1'b0;
  logic moveup, movedown, moveright;
  logic moveup0, movedown0, moveright0;

  always #5 clk = ~clk;

  move_input #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_right(btn_right),
    .moveup(moveup), .movedown(movedown), .moveright(moveright)
  );

  move_input #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut0 (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_right(btn_right),
    .moveup(moveup0), .movedown(movedown0), .moveright(moveright0)
  );

  // expected {right, down, up} after each edge
  logic [2:0] exp_q[$];
  logic [2:0] exp0_q[$];
  int checks = 0;
  int errors = 0;
  logic rst_lvl = 1'b1;

  // model: raw sample history (two edges of sync delay), debounced level,
  // mismatch run length, and time of the last press
  bit m_h1[3], m_h2[3], m_stab[3];
  int m_run[3], m_press[3];
  int tcyc = 0;

  function automatic bit rep_due(input int dt, input int rd);
    if (rd == 0 || dt < rd) return 1'b0;
    return ((dt - rd) % RP) == 0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_h1[c] = 0; m_h2[c] = 0; m_stab[c] = 0; m_run[c] = 0; m_press[c] = 0;
    end
  endtask

  task automatic model_edge(input bit [2:0] r);
    bit [2:0] req, req0;
    bit s, rise;
    for (int c = 0; c < 3; c++) begin
      s = m_h2[c];
      m_h2[c] = m_h1[c];
      m_h1[c] = r[c];
      rise = 0;
      if (s != m_stab[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_stab[c] = s;
          m_run[c] = 0;
          rise = s;
        end
      end else begin
        m_run[c] = 0;
      end
      if (rise) m_press[c] = tcyc;
      req[c]  = rise || (m_stab[c] && rep_due(tcyc - m_press[c], RD));
      req0[c] = rise || (m_stab[c] && rep_due(tcyc - m_press[c], 0));
    end
    tcyc++;
    exp_q.push_back({req[2], req[1] & ~req[0], req[0] & ~req[1]});
    exp0_q.push_back({req0[2], req0[1] & ~req0[0], req0[0] & ~req0[1]});
  endtask

  task automatic cyc(input bit [2:0] r);
    @(negedge clk);
    {btn_right, btn_down, btn_up} = r;
    reset = rst_lvl;
    @(posedge clk);
    if (reset) begin
      model_clear();
      exp_q.push_back(3'b000);
      exp0_q.push_back(3'b000);
    end else begin
      model_edge(r);
    end
  endtask

  task automatic cycn(input bit [2:0] r, input int n);
    for (int i = 0; i < n; i++) cyc(r);
  endtask

  task automatic cyc_async_reset(input bit [2:0] r);
    @(negedge clk);
    {btn_right, btn_down, btn_up} = r;
    #2;
    reset = 1'b1;
    rst_lvl = 1'b1;
    #1;
    checks++;
    if ({moveright, movedown, moveup, moveright0, movedown0, moveup0} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: outputs %b, expected 000000",
               {moveright, movedown, moveup, moveright0, movedown0, moveup0});
    end
    model_clear();
    @(posedge clk);
    exp_q.push_back(3'b000);
    exp0_q.push_back(3'b000);
  endtask

  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({moveright, movedown, moveup} !== e) begin
          errors++;
          $display("FAIL move_rdu t=%0t: got %b expected %b", $time, {moveright, movedown, moveup}, e);
        end
      end
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        checks++;
        if ({moveright0, movedown0, moveup0} !== e) begin
          errors++;
          $display("FAIL move_rdu_norepeat t=%0t: got %b expected %b", $time, {moveright0, movedown0, moveup0}, e);
        end
      end
    end
  end

  initial begin : stimulus
    bit [2:0] lvl, r;
    model_clear();
    cycn(3'b000, 3);
    rst_lvl = 1'b0;
    cycn(3'b000, 4);

    // clean press on up
    cycn(3'b001, 6);
    cycn(3'b000, 14);

    // bouncy press and release on right
    cyc(3'b100); cyc(3'b000); cyc(3'b100); cyc(3'b100); cyc(3'b000); cyc(3'b100);
    cycn(3'b100, 6);
    cyc(3'b000); cyc(3'b000); cyc(3'b000); cyc(3'b100); cyc(3'b000); cyc(3'b000); cyc(3'b100);
    cycn(3'b000, 15);

    // auto-repeat on down
    cycn(3'b010, 30);
    cycn(3'b000, 15);

    // simultaneous up/down, then staggered
    cycn(3'b011, 6);
    cycn(3'b000, 15);
    cycn(3'b001, 2);
    cycn(3'b011, 6);
    cycn(3'b000, 15);

    // reset mid-debounce with right held through deassertion
    cycn(3'b100, 2);
    cyc_async_reset(3'b100);
    cycn(3'b100, 2);
    rst_lvl = 1'b0;
    cycn(3'b100, 12);
    cycn(3'b000, 15);

    // reset asserted while a move pulse is high
    cycn(3'b100, 6);
    cyc_async_reset(3'b100);
    cycn(3'b100, 2);
    rst_lvl = 1'b0;
    cycn(3'b000, 12);

    // long hold: repeats on one DUT, a single pulse on the other
    cycn(3'b001, 40);
    cycn(3'b000, 15);

    // randomized bouncy levels on all channels
    lvl = 3'b000;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 15) == 0) lvl[c] = ~lvl[c];
        r[c] = lvl[c] ^ ($urandom_range(0, 9) == 0);
      end
      cyc(r);
    end
    cycn(3'b000, 15);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", exp_q.size(), exp0_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
